// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and helpers for the pipeline hazard controller
package hazard_pkg;

    localparam int FWD_RF = 0;

    function automatic int fwd_stage(input int k);
        return k + 1;
    endfunction

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int depth, input int load_ready, input int redir_stage);
        return (load_ready >= 0) && (load_ready < depth) &&
               (redir_stage >= 0) && (redir_stage < depth);
    endfunction

endpackage

// File: rtl/src_match.sv
// rtl/src_match.sv - youngest-producer priority match for one decode source register
module src_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int RA_W       = 5,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = 2
) (
    input  logic [RA_W-1:0]       src,
    input  logic                  used,
    input  logic [DEPTH-1:0]      v,
    input  logic [DEPTH-1:0]      w,
    input  logic [DEPTH-1:0]      ld,
    input  logic [DEPTH*RA_W-1:0] rd,
    output logic [SEL_W-1:0]      fwd_sel,
    output logic                  hazard
);

    logic [DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = used && (src != '0) && v[k] && w[k] && (rd[k*RA_W +: RA_W] == src);
        end
    end

    // Scan oldest to youngest so the lowest matching slot overwrites the rest.
    always_comb begin
        fwd_sel = SEL_W'(FWD_RF);
        hazard  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                fwd_sel = SEL_W'(fwd_stage(k));
                hazard  = ld[k] && (k < LOAD_READY);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - in-flight producer tracking, forwarding selects, load-use stall and redirect flush
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int  DEPTH       = 3,
    parameter int  NSRC        = 2,
    parameter int  RA_W        = 5,
    parameter int  LOAD_READY  = 2,
    parameter int  REDIR_STAGE = 1,
    parameter int  CNT_W       = 16,
    localparam int SEL_W       = sel_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic [NSRC*RA_W-1:0]  dec_rs,
    input  logic [NSRC-1:0]       dec_rs_used,
    input  logic [RA_W-1:0]       dec_rd,
    input  logic                  dec_rf_w,
    input  logic                  dec_load,
    input  logic                  redirect,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_fd,
    output logic [NSRC*SEL_W-1:0] fwd_sel,
    output logic [DEPTH-1:0]      stage_valid,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    if (!params_legal(DEPTH, LOAD_READY, REDIR_STAGE)) begin : g_bad_params
        $error("hazard_ctrl: LOAD_READY and REDIR_STAGE must be below DEPTH");
    end

    logic [DEPTH-1:0]      v_q, v_d, w_q, w_d, ld_q, ld_d;
    logic [DEPTH*RA_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [NSRC-1:0]       hazard;
    logic                  stall;
    logic                  issue;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        src_match #(
            .DEPTH      (DEPTH),
            .RA_W       (RA_W),
            .LOAD_READY (LOAD_READY),
            .SEL_W      (SEL_W)
        ) u_match (
            .src     (dec_rs[i*RA_W +: RA_W]),
            .used    (dec_rs_used[i]),
            .v       (v_q),
            .w       (w_q),
            .ld      (ld_q),
            .rd      (rd_q),
            .fwd_sel (fwd_sel[i*SEL_W +: SEL_W]),
            .hazard  (hazard[i])
        );
    end

    // Redirect outranks the load-use stall: the stalled D instruction is being flushed anyway.
    assign stall       = dec_valid && (|hazard) && !redirect;
    assign issue       = dec_valid && !stall && !redirect;
    assign stall_f     = stall;
    assign stall_d     = stall;
    assign flush_fd    = redirect;
    assign stage_valid = v_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    always_comb begin
        v_d  = '0;
        w_d  = '0;
        ld_d = '0;
        rd_d = '0;
        v_d[0]            = issue;
        w_d[0]            = issue && dec_rf_w;
        ld_d[0]           = issue && dec_load;
        rd_d[RA_W-1:0]    = dec_rd;
        // Slots at or younger than the redirecting stage are wrong-path work.
        for (int k = 1; k < DEPTH; k++) begin
            v_d[k]                 = v_q[k-1] && !(redirect && (k <= REDIR_STAGE));
            w_d[k]                 = w_q[k-1];
            ld_d[k]                = ld_q[k-1];
            rd_d[k*RA_W +: RA_W]   = rd_q[(k-1)*RA_W +: RA_W];
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q         <= '0;
            w_q         <= '0;
            ld_q        <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            w_q         <= w_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int DEPTH       = 3;
    localparam int NSRC        = 2;
    localparam int RA_W        = 5;
    localparam int LOAD_READY  = 2;
    localparam int REDIR_STAGE = 1;
    localparam int CNT_W       = 4;
    localparam int SEL_W       = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  dec_valid;
    logic [NSRC*RA_W-1:0]  dec_rs;
    logic [NSRC-1:0]       dec_rs_used;
    logic [RA_W-1:0]       dec_rd;
    logic                  dec_rf_w;
    logic                  dec_load;
    logic                  redirect;
    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_fd;
    logic [NSRC*SEL_W-1:0] fwd_sel;
    logic [DEPTH-1:0]      stage_valid;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    typedef struct packed {
        logic       v;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       rfw;
        logic       ld;
        logic       redir;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic       flush;
        logic       dc;
        logic [1:0] f0;
        logic [1:0] f1;
        logic [2:0] sv;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    hazard_ctrl #(
        .DEPTH       (DEPTH),
        .NSRC        (NSRC),
        .RA_W        (RA_W),
        .LOAD_READY  (LOAD_READY),
        .REDIR_STAGE (REDIR_STAGE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_rs      (dec_rs),
        .dec_rs_used (dec_rs_used),
        .dec_rd      (dec_rd),
        .dec_rf_w    (dec_rf_w),
        .dec_load    (dec_load),
        .redirect    (redirect),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_fd    (flush_fd),
        .fwd_sel     (fwd_sel),
        .stage_valid (stage_valid),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk_s(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                                   input logic [1:0] used, input logic [4:0] rd, input logic rfw,
                                   input logic ld, input logic redir);
        stim_t s;
        s = '{v: v, rs0: rs0, rs1: rs1, used: used, rd: rd, rfw: rfw, ld: ld, redir: redir};
        return s;
    endfunction

    function automatic exp_t mk_e(input logic stall, input logic flush, input logic dc,
                                  input logic [1:0] f0, input logic [1:0] f1, input logic [2:0] sv);
        exp_t e;
        e = '{stall: stall, flush: flush, dc: dc, f0: f0, f1: f1, sv: sv};
        return e;
    endfunction

    task automatic drive(input stim_t s);
        @(negedge clk);
        dec_valid   = s.v;
        dec_rs      = {s.rs1, s.rs0};
        dec_rs_used = s.used;
        dec_rd      = s.rd;
        dec_rf_w    = s.rfw;
        dec_load    = s.ld;
        redirect    = s.redir;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(mk_s(0, 0, 0, 2'b00, 0, 0, 0, 0));
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] got, want;
        @(negedge clk);
        reset       = 1'b0;
        dec_valid   = 1'b1;
        dec_rs      = {5'd8, 5'd8};
        dec_rs_used = 2'b11;
        dec_rd      = 5'd8;
        dec_rf_w    = 1'b1;
        dec_load    = 1'b1;
        redirect    = 1'b1;
        @(negedge clk);
        #2;
        got  = {stall_f, stall_d, flush_fd, fwd_sel, stage_valid};
        want = 10'b00_1_0000_000;
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b", got, want);
        end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
        end
        redirect = 1'b0;
        #1;
        checks++;
        if (flush_fd !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush_follows_redirect: got %b required 0", flush_fd);
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        logic [9:0] got, want;
        apply_reset();
        st.push_back(mk_s(1, 1, 2, 2'b11, 3, 1, 0, 0)); ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b000));
        st.push_back(mk_s(1, 3, 5, 2'b11, 4, 1, 0, 0)); ex.push_back(mk_e(0, 0, 0, 1, 0, 3'b001));
        st.push_back(mk_s(1, 0, 3, 2'b11, 6, 1, 0, 0)); ex.push_back(mk_e(0, 0, 0, 0, 2, 3'b011));
        st.push_back(mk_s(1, 4, 3, 2'b11, 7, 1, 0, 0)); ex.push_back(mk_e(0, 0, 0, 2, 3, 3'b111));
        for (int c = 0; c < st.size(); c++) begin
            drive(st[c]);
            exp_q.push_back(ex[c]);
            #2;
            e    = exp_q.pop_front();
            got  = {stall_f, stall_d, flush_fd, e.dc ? {e.f1, e.f0} : fwd_sel, stage_valid};
            want = {e.stall, e.stall, e.flush, e.f1, e.f0, e.sv};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b required %b", c, got, want);
            end
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL back_to_back_stall_cnt: got %0d required 0", stall_cnt);
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        logic [9:0] got, want;
        apply_reset();
        st.push_back(mk_s(1, 29, 0, 2'b01, 8, 1, 1, 0)); ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b000));
        st.push_back(mk_s(1, 8, 8, 2'b11, 9, 1, 0, 0));  ex.push_back(mk_e(1, 0, 1, 0, 0, 3'b001));
        st.push_back(mk_s(1, 8, 8, 2'b11, 9, 1, 0, 0));  ex.push_back(mk_e(1, 0, 1, 0, 0, 3'b010));
        st.push_back(mk_s(1, 8, 8, 2'b11, 9, 1, 0, 0));  ex.push_back(mk_e(0, 0, 0, 3, 3, 3'b100));
        st.push_back(mk_s(0, 0, 0, 2'b00, 0, 0, 0, 0));  ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b001));
        for (int c = 0; c < st.size(); c++) begin
            drive(st[c]);
            exp_q.push_back(ex[c]);
            #2;
            e    = exp_q.pop_front();
            got  = {stall_f, stall_d, flush_fd, e.dc ? {e.f1, e.f0} : fwd_sel, stage_valid};
            want = {e.stall, e.stall, e.flush, e.f1, e.f0, e.sv};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use cycle %0d: got %b required %b", c, got, want);
            end
        end
        checks++;
        if (stall_cnt !== 4'd2 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL load_use_counters: got %0d/%0d required 2/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reg_zero();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        logic [9:0] got, want;
        apply_reset();
        st.push_back(mk_s(1, 0, 0, 2'b00, 0, 1, 1, 0)); ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b000));
        st.push_back(mk_s(1, 0, 0, 2'b11, 0, 1, 0, 0)); ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b001));
        st.push_back(mk_s(1, 0, 0, 2'b11, 0, 1, 0, 0)); ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b011));
        for (int c = 0; c < st.size(); c++) begin
            drive(st[c]);
            exp_q.push_back(ex[c]);
            #2;
            e    = exp_q.pop_front();
            got  = {stall_f, stall_d, flush_fd, e.dc ? {e.f1, e.f0} : fwd_sel, stage_valid};
            want = {e.stall, e.stall, e.flush, e.f1, e.f0, e.sv};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reg_zero cycle %0d: got %b required %b", c, got, want);
            end
        end
    endtask

    task automatic test_redirect_stall();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        logic [9:0] got, want;
        apply_reset();
        st.push_back(mk_s(1, 4, 5, 2'b11, 0, 0, 0, 0));   ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b000));
        st.push_back(mk_s(1, 29, 0, 2'b01, 8, 1, 1, 0));  ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b001));
        st.push_back(mk_s(1, 8, 0, 2'b01, 10, 1, 0, 1));  ex.push_back(mk_e(0, 1, 1, 0, 0, 3'b011));
        st.push_back(mk_s(0, 0, 0, 2'b00, 0, 0, 0, 0));   ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b100));
        for (int c = 0; c < st.size(); c++) begin
            drive(st[c]);
            exp_q.push_back(ex[c]);
            #2;
            e    = exp_q.pop_front();
            got  = {stall_f, stall_d, flush_fd, e.dc ? {e.f1, e.f0} : fwd_sel, stage_valid};
            want = {e.stall, e.stall, e.flush, e.f1, e.f0, e.sv};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL redirect_stall cycle %0d: got %b required %b", c, got, want);
            end
        end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd1) begin
            errors++;
            $display("FAIL redirect_counters: got %0d/%0d required 0/1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_double_producer();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        logic [9:0] got, want;
        apply_reset();
        st.push_back(mk_s(1, 1, 2, 2'b11, 9, 1, 0, 0));   ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b000));
        st.push_back(mk_s(1, 0, 0, 2'b00, 0, 0, 0, 0));   ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b001));
        st.push_back(mk_s(1, 3, 4, 2'b11, 9, 1, 0, 0));   ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b011));
        st.push_back(mk_s(1, 9, 9, 2'b11, 10, 1, 0, 0));  ex.push_back(mk_e(0, 0, 0, 1, 1, 3'b111));
        st.push_back(mk_s(1, 9, 10, 2'b11, 11, 1, 0, 0)); ex.push_back(mk_e(0, 0, 0, 2, 1, 3'b111));
        for (int c = 0; c < st.size(); c++) begin
            drive(st[c]);
            exp_q.push_back(ex[c]);
            #2;
            e    = exp_q.pop_front();
            got  = {stall_f, stall_d, flush_fd, e.dc ? {e.f1, e.f0} : fwd_sel, stage_valid};
            want = {e.stall, e.stall, e.flush, e.f1, e.f0, e.sv};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL double_producer cycle %0d: got %b required %b", c, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  e;
        logic [9:0] got, want;
        apply_reset();
        st.push_back(mk_s(1, 29, 0, 2'b01, 8, 1, 1, 0)); ex.push_back(mk_e(0, 0, 0, 0, 0, 3'b000));
        st.push_back(mk_s(1, 8, 0, 2'b01, 11, 1, 0, 0)); ex.push_back(mk_e(1, 0, 1, 0, 0, 3'b001));
        st.push_back(mk_s(1, 8, 0, 2'b01, 11, 1, 0, 0)); ex.push_back(mk_e(1, 0, 1, 0, 0, 3'b010));
        for (int c = 0; c < st.size(); c++) begin
            drive(st[c]);
            exp_q.push_back(ex[c]);
            #2;
            e    = exp_q.pop_front();
            got  = {stall_f, stall_d, flush_fd, e.dc ? {e.f1, e.f0} : fwd_sel, stage_valid};
            want = {e.stall, e.stall, e.flush, e.f1, e.f0, e.sv};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_stall cycle %0d: got %b required %b", c, got, want);
            end
        end
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mid_stall_cnt_before_reset: got %0d required 1", stall_cnt);
        end
        reset = 1'b0;
        #1;
        got  = {stall_f, stall_d, flush_fd, fwd_sel, stage_valid};
        want = 10'b00_0_0000_000;
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL mid_stall_async_clear: got %b required %b", got, want);
        end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_stall_counters_clear: got %0d/%0d required 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(mk_s(1, 11, 0, 2'b01, 12, 1, 0, 0));
        exp_q.push_back(mk_e(0, 0, 0, 1, 0, 3'b001));
        #2;
        e    = exp_q.pop_front();
        got  = {stall_f, stall_d, flush_fd, fwd_sel, stage_valid};
        want = {e.stall, e.stall, e.flush, e.f1, e.f0, e.sv};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL resume_after_reset: got %b required %b", got, want);
        end
    endtask

    task automatic test_flush_saturate();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            drive(mk_s(0, 0, 0, 2'b00, 0, 0, 0, 1));
        end
        drive(mk_s(0, 0, 0, 2'b00, 0, 0, 0, 0));
        #2;
        checks++;
        if (flush_cnt !== 4'hf) begin
            errors++;
            $display("FAIL flush_cnt_saturate: got %0d required 15", flush_cnt);
        end
        drive(mk_s(0, 0, 0, 2'b00, 0, 0, 0, 1));
        @(negedge clk);
        #2;
        checks++;
        if (flush_cnt !== 4'hf || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL flush_cnt_hold: got %0d/%0d required 15/0", flush_cnt, stall_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        dec_valid   = 1'b0;
        dec_rs      = '0;
        dec_rs_used = '0;
        dec_rd      = '0;
        dec_rf_w    = 1'b0;
        dec_load    = 1'b0;
        redirect    = 1'b0;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_reg_zero();
        test_redirect_stall();
        test_double_producer();
        test_reset_mid_stall();
        test_flush_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
